// File: rtl/sweep_pkg.sv
// Shared types and defaults for the sweep result collector.
package sweep_pkg;

  localparam int DEF_POINTS     = 200;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RES_WIDTH  = 32;

  // Collector top-level phase: waiting, capturing a sweep, streaming it out.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } sweep_state_e;

  // One stored measurement; the buffer word is {freq, mod, phase}.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] freq;
    logic [DEF_RES_WIDTH-1:0]  mod;
    logic [DEF_RES_WIDTH-1:0]  phase;
  } result_entry_t;

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result buffer: one write port, one registered read port.
module result_ram #(
  parameter int DEPTH = 200,
  parameter int AW    = 8,
  parameter int W     = 96
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  // Write port: store the captured word at the write address.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: data appears one cycle after the address is presented.
  always_ff @(posedge i_clk) begin
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sweep_result_collector.sv
// Captures per-frequency results during a sweep, then streams them out
// in capture order once the sweep is complete.
//
// Output stream handshake: an entry moves when out_valid && out_ready are
// both high at a rising clk125 edge. While out_valid is high and out_ready
// is low every out_* field holds its value. After each transfer out_valid
// drops for exactly one cycle while the next entry is read from the buffer.
module sweep_result_collector
  import sweep_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RES_WIDTH    = DEF_RES_WIDTH,
  parameter int POINTS       = DEF_POINTS,
  parameter int IDX_WIDTH    = 8,
  parameter int GUARD_CYCLES = 4096
) (
  input  logic                  clk125,
  input  logic                  areset_n,
  input  logic                  clear,
  input  logic                  meas_valid,
  input  logic [DATA_WIDTH-1:0] meas_freq,
  input  logic [RES_WIDTH-1:0]  meas_mod,
  input  logic [RES_WIDTH-1:0]  meas_phase,
  input  logic                  sweep_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic [DATA_WIDTH-1:0] out_freq,
  output logic [RES_WIDTH-1:0]  out_mod,
  output logic [RES_WIDTH-1:0]  out_phase,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow,
  output logic [IDX_WIDTH:0]    n_points,
  output sweep_state_e          dbg_state
);

  // Buffer word width; equals $bits(result_entry_t) at default widths.
  localparam int EW = DATA_WIDTH + 2 * RES_WIDTH;
  localparam int GW = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [IDX_WIDTH:0]   PTS        = (IDX_WIDTH+1)'(POINTS);
  localparam logic [IDX_WIDTH:0]   WR_ONE     = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0] RD_ONE     = IDX_WIDTH'(1);
  localparam logic [GW-1:0]        GUARD_ONE  = GW'(1);
  localparam logic [GW-1:0]        GUARD_LAST = GW'(GUARD_CYCLES - 1);

  sweep_state_e          r_state;
  logic [IDX_WIDTH:0]    r_wr_ptr;
  logic [IDX_WIDTH-1:0]  r_rd_ptr;
  logic                  r_done_pending;
  logic [GW-1:0]         r_guard;
  logic                  r_drain_start;
  logic                  r_rd_pend;
  logic                  r_out_valid;
  logic [IDX_WIDTH-1:0]  r_out_index;
  logic [DATA_WIDTH-1:0] r_out_freq;
  logic [RES_WIDTH-1:0]  r_out_mod;
  logic [RES_WIDTH-1:0]  r_out_phase;
  logic                  r_out_last;
  logic                  r_overflow;
  logic [IDX_WIDTH:0]    r_n_points;

  logic                  w_space;
  logic                  w_wr_en;
  logic [IDX_WIDTH:0]    w_wr_ptr_next;
  logic                  w_go_drain;
  logic                  w_xfer;
  logic [IDX_WIDTH-1:0]  w_rd_addr;
  logic [EW-1:0]         w_wr_data;
  logic [EW-1:0]         w_rd_data;

  // Capture and read-address steering for the buffer.
  always_comb begin
    w_space       = (r_wr_ptr < PTS);
    w_wr_en       = meas_valid && !clear &&
                    ((r_state == ST_IDLE) || ((r_state == ST_COLLECT) && w_space));
    w_wr_ptr_next = w_wr_en ? (r_wr_ptr + WR_ONE) : r_wr_ptr;
    // A result while a sweep end is known (now or earlier) closes the sweep;
    // otherwise the guard window expiring closes it.
    w_go_drain    = meas_valid ? (sweep_done || r_done_pending)
                               : (r_done_pending && !sweep_done && (r_guard == GUARD_LAST));
    w_xfer        = r_out_valid && out_ready;
    // Prefetch the following entry in the same cycle as a transfer.
    w_rd_addr     = w_xfer ? (r_rd_ptr + RD_ONE) : r_rd_ptr;
    w_wr_data     = {meas_freq, meas_mod, meas_phase};
  end

  result_ram #(
    .DEPTH (POINTS),
    .AW    (IDX_WIDTH),
    .W     (EW)
  ) u_ram (
    .i_clk     (clk125),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[IDX_WIDTH-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Collector FSM: capture phase, sweep-end guard, and stream-out sequencing.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_done_pending <= 1'b0;
      r_guard        <= '0;
      r_drain_start  <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_index    <= '0;
      r_out_freq     <= '0;
      r_out_mod      <= '0;
      r_out_phase    <= '0;
      r_out_last     <= 1'b0;
      r_overflow     <= 1'b0;
      r_n_points     <= '0;
    end else if (clear) begin
      // Abort: drop everything in flight but keep the last sweep size.
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_done_pending <= 1'b0;
      r_guard        <= '0;
      r_drain_start  <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // First result opens a sweep; a lone sweep_done here is ignored.
          if (meas_valid) begin
            r_wr_ptr <= WR_ONE;
            r_state  <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (meas_valid) begin
            if (w_space) begin
              r_wr_ptr <= r_wr_ptr + WR_ONE;
            end else begin
              r_overflow <= 1'b1;
            end
          end
          if (w_go_drain) begin
            r_state       <= ST_DRAIN;
            r_n_points    <= w_wr_ptr_next;
            r_rd_ptr      <= '0;
            r_drain_start <= 1'b1;
          end else if (sweep_done) begin
            r_done_pending <= 1'b1;
            r_guard        <= '0;
          end else if (r_done_pending) begin
            r_guard <= r_guard + GUARD_ONE;
          end
        end

        ST_DRAIN: begin
          if (meas_valid) begin
            r_overflow <= 1'b1;
          end
          // First cycle of the drain presents address 0 to the buffer.
          if (r_drain_start) begin
            r_drain_start <= 1'b0;
            r_rd_pend     <= 1'b1;
          end
          // Buffer data for r_rd_ptr is ready: present it on the stream.
          if (r_rd_pend) begin
            r_rd_pend   <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_index <= r_rd_ptr;
            r_out_freq  <= w_rd_data[EW-1 -: DATA_WIDTH];
            r_out_mod   <= w_rd_data[2*RES_WIDTH-1 -: RES_WIDTH];
            r_out_phase <= w_rd_data[RES_WIDTH-1:0];
            r_out_last  <= ({1'b0, r_rd_ptr} == (r_n_points - WR_ONE));
          end
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_state        <= ST_IDLE;
              r_wr_ptr       <= '0;
              r_rd_ptr       <= '0;
              r_done_pending <= 1'b0;
              r_out_last     <= 1'b0;
            end else begin
              r_rd_ptr  <= r_rd_ptr + RD_ONE;
              r_rd_pend <= 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_freq  = r_out_freq;
  assign out_mod   = r_out_mod;
  assign out_phase = r_out_phase;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;
  assign n_points  = r_n_points;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
